softmax_out_serializer: RTL and testbench

//  Stage directly downstream of softmax: captures each N-wide probability vector (prob_flat on

---
 rtl/softmax_pkg.sv | 16 +
 rtl/softmax_vec_fifo.sv | 50 +++++
 rtl/softmax_out_serializer.sv | 82 ++++++++
 tb/tb_softmax_out_serializer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared constants for the softmax datapath and its output serializer.
//   SM_N      elements per probability vector
//   SM_W      element width (Q6.10 bit pattern)
//   SM_FRAC   fractional bits of the element format
//   SM_IDX_W  width of an element index within a vector
package softmax_pkg;
  localparam int SM_N     = 32;
  localparam int SM_W     = 16;
  localparam int SM_FRAC  = 10;
  localparam int SM_IDX_W = $clog2(SM_N);

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;
endpackage

// File: rtl/softmax_vec_fifo.sv
// Vector FIFO: DEPTH slots, each holding one whole N*W-bit vector.
//   clk, rst     clock, synchronous active-low reset (pointers only)
//   wr_en        push wr_data (caller guarantees !full or simultaneous pop)
//   rd_en        pop head slot
//   rd_data      head slot, combinational read of registered storage
//   full/empty   occupancy flags
//   count        vectors held, 0..DEPTH
module softmax_vec_fifo
  import softmax_pkg::*;
#(
  parameter int N     = SM_N,
  parameter int W     = SM_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [N*W-1:0]             wr_data,
  input  logic                       rd_en,
  output logic [N*W-1:0]             rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][N*W-1:0] mem;
  logic [AW:0]               wr_ptr, rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the slot bits match.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
endmodule

// File: rtl/softmax_out_serializer.sv
// Buffers softmax output vectors and streams them one element per beat.
//   clk, rst      clock, synchronous active-low reset
//   en            input capture enable (output side always runs)
//   valid_in      vector present on prob_flat
//   prob_flat     N elements, element i at [W*i +: W]
//   m_data/m_idx/m_last/m_valid/m_ready   element stream, valid/ready handshake
//   full/empty    buffer occupancy
//   overflow      sticky: a captured vector was dropped because buffer was full
//   vec_count     vectors held
module softmax_out_serializer
  import softmax_pkg::*;
#(
  parameter int N     = SM_N,
  parameter int W     = SM_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       valid_in,
  input  logic [N*W-1:0]             prob_flat,
  output logic [W-1:0]               m_data,
  output logic [$clog2(N)-1:0]       m_idx,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     vec_count
);
  localparam int IW = $clog2(N);

  ser_state_e            state, state_nxt;
  logic [N*W-1:0]        head_flat;
  logic [N-1:0][W-1:0]   head;
  logic                  beat, pop_vec, wr;

  assign beat    = m_valid & m_ready;
  assign pop_vec = beat & m_last;
  // A pop on the same edge frees the slot, so a full buffer can still accept.
  assign wr      = en & valid_in & (!full | pop_vec);

  softmax_vec_fifo #(.N(N), .W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr),
    .wr_data (prob_flat),
    .rd_en   (pop_vec),
    .rd_data (head_flat),
    .full    (full),
    .empty   (empty),
    .count   (vec_count)
  );

  assign head    = head_flat;
  assign m_data  = head[m_idx];
  assign m_last  = (m_idx == IW'(N-1));
  // STREAM tracks !empty exactly; it is the registered form of that condition.
  assign m_valid = (state == SER_STREAM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SER_IDLE;
      m_idx    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat) m_idx <= m_last ? '0 : m_idx + 1'b1;
      if (en & valid_in & full & !pop_vec) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SER_IDLE:   if (wr) state_nxt = SER_STREAM;
      SER_STREAM: if (pop_vec && !wr && vec_count == 1) state_nxt = SER_IDLE;
      default:    state_nxt = SER_IDLE;
    endcase
  end
endmodule

// File: tb/tb_softmax_out_serializer.sv
module tb_softmax_out_serializer;
  localparam int N = 32, W = 16, DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst, en, valid_in, m_ready;
  logic [N*W-1:0] prob_flat;
  logic [W-1:0]   m_data;
  logic [4:0]     m_idx;
  logic           m_last, m_valid, full, empty, overflow;
  logic [2:0]     vec_count;

  softmax_out_serializer #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .prob_flat(prob_flat),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .full(full), .empty(empty), .overflow(overflow),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of whole vectors, a position within the head
  // vector, and a sticky drop flag.
  logic [N*W-1:0] q[$];
  int             pos;
  bit             ovf;
  bit             armed;
  int             vectors, miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] mkvec(input int base);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = W'(base + i);
    return v;
  endfunction

  function automatic logic [N*W-1:0] rndvec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = W'($urandom);
    return v;
  endfunction

  // One clock: apply inputs, check outputs against the model, advance both.
  task automatic cyc(input bit r, input bit e, input bit v,
                     input logic [N*W-1:0] d, input bit rdy);
    logic [N*W-1:0] hv;
    bit             pop, fl;
    rst = r; en = e; valid_in = v; prob_flat = d; m_ready = rdy;
    #1;
    if (armed) begin
      chk("m_valid",   m_valid,   q.size() != 0);
      chk("empty",     empty,     q.size() == 0);
      chk("full",      full,      q.size() == DEPTH);
      chk("vec_count", vec_count, q.size());
      chk("overflow",  overflow,  ovf);
      chk("m_idx",     m_idx,     pos);
      chk("m_last",    m_last,    pos == N-1);
      if (q.size() != 0) begin
        hv = q[0];
        chk("m_data", m_data, hv[W*pos +: W]);
      end
    end
    @(posedge clk);
    if (!r) begin
      q.delete(); pos = 0; ovf = 0; armed = 1;
    end else begin
      fl  = (q.size() == DEPTH);
      pop = (q.size() != 0) && rdy && (pos == N-1);
      if (e && v && fl && !pop) ovf = 1;
      if ((q.size() != 0) && rdy) begin
        if (pos == N-1) begin pos = 0; void'(q.pop_front()); end
        else pos++;
      end
      if (e && v && (!fl || pop)) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N*W-1:0] z;
    z = '0;
    vectors = 0; miscompares = 0; armed = 0; pos = 0; ovf = 0;
    rst = 0; en = 0; valid_in = 0; prob_flat = '0; m_ready = 0;
    @(negedge clk);
    cyc(0, 0, 0, z, 0);

    // 1: random activity, then reset held two cycles
    for (int k = 0; k < 60; k++)
      cyc(1, ($urandom % 4) != 0, ($urandom % 3) == 0, rndvec(), $urandom % 2);
    cyc(0, 1, 1, rndvec(), 1);
    cyc(0, 1, 1, rndvec(), 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_vec_count", vec_count, 0);
    chk("rst_overflow", overflow, 0);

    // 2: one vector, consumer always ready
    cyc(1, 1, 1, mkvec(16'h0100), 1);
    chk("lat_m_valid", m_valid, 1);
    chk("lat_first_data", m_data, 16'h0100);
    for (int k = 0; k < 34; k++) cyc(1, 1, 0, z, 1);

    // 3: same vector, ready toggling
    cyc(1, 1, 1, mkvec(16'h0100), 0);
    for (int k = 0; k < 68; k++) cyc(1, 1, 0, z, k % 2 == 0);

    // 4: five back-to-back vectors with no consumer, then drain
    for (int vv = 0; vv < 5; vv++) cyc(1, 1, 1, mkvec(16'hA000 + vv * 256), 0);
    chk("ovf_set", overflow, 1);
    for (int k = 0; k < 132; k++) cyc(1, 1, 0, z, 1);
    chk("ovf_sticky", overflow, 1);

    // 5: full buffer with head on its last beat accepts a new vector
    cyc(0, 0, 0, z, 0);
    for (int vv = 0; vv < 4; vv++) cyc(1, 1, 1, mkvec(16'hB000 + vv * 256), 0);
    for (int k = 0; k < 31; k++) cyc(1, 1, 0, z, 1);
    cyc(1, 1, 1, mkvec(16'hC000), 1);
    chk("pop_wr_overflow", overflow, 0);
    chk("pop_wr_count", vec_count, 4);
    for (int k = 0; k < 140; k++) cyc(1, 1, 0, z, 1);

    // 6: reset mid-vector, disabled capture, then a fresh vector
    cyc(1, 1, 1, mkvec(16'h0300), 1);
    for (int k = 0; k < 10; k++) cyc(1, 1, 0, z, 1);
    cyc(0, 1, 0, z, 1);
    chk("midrst_m_valid", m_valid, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, rndvec(), 1);
    chk("en0_empty", empty, 1);
    chk("en0_overflow", overflow, 0);
    cyc(1, 1, 1, mkvec(16'h0400), 1);
    chk("fresh_m_idx", m_idx, 0);
    for (int k = 0; k < 34; k++) cyc(1, 1, 0, z, 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++)
      cyc(1, ($urandom % 4) != 0, ($urandom % 8) == 0, rndvec(), ($urandom % 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
